// File: rtl/count_pwm_stage_pkg.sv
// Shared types and constants for the counter-driven PWM stage.
package count_pwm_stage_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } mon_state_e;

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned CNT_MAX   = 2**CNT_WIDTH - 1;
  localparam int unsigned DUTY_FULL = 2**CNT_WIDTH;

endpackage

// File: rtl/count_pwm_stage_if.sv
// Duty-value valid/ready channel between a duty source and the PWM stage.
interface count_pwm_stage_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH:0] duty_in;
  logic           duty_valid;
  logic           duty_ready;

  modport master (output duty_in, output duty_valid, input duty_ready);
  modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/count_pwm_stage_wrap_monitor.sv
// Tracks the upstream counter: flags wraps (combinational) and sticky
// sequence errors; the first cycle after reset only seeds the history.
module count_wrap_monitor
  import count_pwm_stage_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  output logic             wrap,
  output logic             seq_err
);

  localparam logic [WIDTH-1:0] MAX_CNT = '1;

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             seq_err_q, seq_err_d;
  logic [WIDTH-1:0] expect_cnt;
  logic             skip;

  always_comb begin
    state_d    = RUN;
    prev_d     = count_in;
    seq_err_d  = seq_err_q;
    wrap       = 1'b0;
    skip       = 1'b0;
    expect_cnt = prev_q + WIDTH'(1);
    if (state_q == RUN) begin
      wrap = (prev_q == MAX_CNT) && (count_in == '0);
      skip = (count_in != expect_cnt);
    end
    // A fresh skip outranks a simultaneous clear.
    if (skip) begin
      seq_err_d = 1'b1;
    end else if (err_clr) begin
      seq_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      prev_q    <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;

endmodule

// File: rtl/count_pwm_stage.sv
// PWM generator driven by an upstream free-running counter; duty updates are
// buffered through a one-entry pending register and applied only at wraps.
module count_pwm_stage
  import count_pwm_stage_pkg::*;
#(
  parameter int unsigned WIDTH  = CNT_WIDTH,
  parameter bit          INVERT = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count_in,
  count_pwm_stage_if.slave         duty,
  input  logic                     err_clr,
  output logic                     pwm_out,
  output logic                     wrap_pulse,
  output logic [WIDTH:0]           duty_active,
  output logic                     seq_err
);

  localparam logic [WIDTH:0] FULL = {1'b1, {WIDTH{1'b0}}};

  logic           wrap;
  logic [WIDTH:0] pending_q, pending_d;
  logic           pending_vld_q, pending_vld_d;
  logic [WIDTH:0] duty_active_q, duty_active_d;
  logic           pwm_q, pwm_d;
  logic           wrap_pulse_q, wrap_pulse_d;
  logic [WIDTH:0] duty_sat;
  logic [WIDTH:0] eff_duty;
  logic           apply;

  count_wrap_monitor #(
    .WIDTH(WIDTH)
  ) u_mon (
    .clk      (clk),
    .reset    (reset),
    .count_in (count_in),
    .err_clr  (err_clr),
    .wrap     (wrap),
    .seq_err  (seq_err)
  );

  assign duty.duty_ready = !pending_vld_q;

  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    duty_active_d = duty_active_q;
    duty_sat      = (duty.duty_in > FULL) ? FULL : duty.duty_in;
    apply         = wrap && pending_vld_q;
    eff_duty      = apply ? pending_q : duty_active_q;
    // Transfer only happens when pending is empty, so it never collides
    // with an apply; a transfer on a wrap cycle waits for the next wrap.
    if (apply) begin
      duty_active_d = pending_q;
      pending_vld_d = 1'b0;
    end
    if (duty.duty_valid && !pending_vld_q) begin
      pending_d     = duty_sat;
      pending_vld_d = 1'b1;
    end
    pwm_d        = ({1'b0, count_in} < eff_duty) ^ INVERT;
    wrap_pulse_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      duty_active_q <= '0;
      pwm_q         <= 1'b0;
      wrap_pulse_q  <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
      wrap_pulse_q  <= wrap_pulse_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign duty_active = duty_active_q;

endmodule

// File: tb/tb_count_pwm_stage.sv
// Scoreboard bench: normal and inverted stages share stimulus; expected
// outputs are queued per cycle by a behavioural model and popped after the edge.
module tb_count_pwm_stage;
  import count_pwm_stage_pkg::*;

  logic       clk;
  logic       reset;
  logic [3:0] count_in;
  logic       err_clr;

  logic       pwm_out, wrap_pulse, seq_err;
  logic [4:0] duty_active;
  logic       pwm_out_i, wrap_pulse_i, seq_err_i;
  logic [4:0] duty_active_i;

  count_pwm_stage_if #(.WIDTH(4)) dif ();
  count_pwm_stage_if #(.WIDTH(4)) dif_i ();

  count_pwm_stage #(.WIDTH(4), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .duty(dif),
    .err_clr(err_clr), .pwm_out(pwm_out), .wrap_pulse(wrap_pulse),
    .duty_active(duty_active), .seq_err(seq_err)
  );

  count_pwm_stage #(.WIDTH(4), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .count_in(count_in), .duty(dif_i),
    .err_clr(err_clr), .pwm_out(pwm_out_i), .wrap_pulse(wrap_pulse_i),
    .duty_active(duty_active_i), .seq_err(seq_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pwm;
    logic       pwm_inv;
    logic       wrap;
    logic       seq;
    logic       ready;
    logic [4:0] active;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] cnt;
  bit         m_run;
  logic [3:0] m_prev;
  bit         m_seq, m_pvld, m_pwm, m_pwm_inv, m_wrap;
  int         m_pend, m_active;
  bit         last_xfer;
  int         n_hi, n_wraps;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic rst, input logic dval, input logic [4:0] din, input logic eclr);
    bit         w, e;
    int         eff;
    logic [3:0] nxt;
    if (rst) begin
      m_run = 0; m_prev = 4'd0; m_seq = 0; m_pvld = 0; m_pend = 0;
      m_active = 0; m_pwm = 0; m_pwm_inv = 0; m_wrap = 0; last_xfer = 0;
    end else begin
      nxt = m_prev + 4'd1;
      w   = m_run && (m_prev == 4'd15) && (cnt == 4'd0);
      e   = m_run && (cnt != nxt);
      eff = (w && m_pvld) ? m_pend : m_active;
      m_pwm     = (int'(cnt) < eff);
      m_pwm_inv = !(int'(cnt) < eff);
      m_wrap    = w;
      if (e) m_seq = 1;
      else if (eclr) m_seq = 0;
      last_xfer = dval && !m_pvld;
      if (w && m_pvld) begin
        m_active = m_pend;
        m_pvld   = 0;
      end else if (last_xfer) begin
        m_pend = (int'(din) > 16) ? 16 : int'(din);
        m_pvld = 1;
      end
      m_prev = cnt;
      m_run  = 1;
    end
  endtask

  task automatic step(input logic rst, input logic dval, input logic [4:0] din, input logic eclr);
    exp_t ex, got;
    reset = rst; count_in = cnt; err_clr = eclr;
    dif.duty_valid = dval;   dif.duty_in = din;
    dif_i.duty_valid = dval; dif_i.duty_in = din;
    model(rst, dval, din, eclr);
    ex.pwm = m_pwm; ex.pwm_inv = m_pwm_inv; ex.wrap = m_wrap; ex.seq = m_seq;
    ex.ready = !m_pvld; ex.active = 5'(m_active);
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val("pwm",          pwm_out,          got.pwm);
    check_val("pwm_inv",      pwm_out_i,        got.pwm_inv);
    check_val("wrap",         wrap_pulse,       got.wrap);
    check_val("wrap_inv",     wrap_pulse_i,     got.wrap);
    check_val("seq_err",      seq_err,          got.seq);
    check_val("seq_err_inv",  seq_err_i,        got.seq);
    check_val("ready",        dif.duty_ready,   got.ready);
    check_val("ready_inv",    dif_i.duty_ready, got.ready);
    check_val("active",       duty_active,      got.active);
    check_val("active_inv",   duty_active_i,    got.active);
    if (pwm_out) n_hi++;
    if (wrap_pulse) n_wraps++;
  endtask

  task automatic tick(input logic dval, input logic [4:0] din);
    step(1'b0, dval, din, 1'b0);
    cnt = cnt + 4'd1;
  endtask

  task automatic run_to(input logic [3:0] target);
    for (int i = 0; i < 16 && cnt != target; i++) tick(1'b0, 5'd0);
  endtask

  task automatic through_wrap();
    run_to(4'd0);
    tick(1'b0, 5'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cnt = 4'd0; reset = 1'b1; count_in = 4'd0; err_clr = 1'b0;
    dif.duty_valid = 1'b0; dif.duty_in = 5'd0;
    dif_i.duty_valid = 1'b0; dif_i.duty_in = 5'd0;
    step(1'b1, 1'b0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check_val("rst_pwm",    pwm_out,        0);
    check_val("rst_ready",  dif.duty_ready, 1);
    check_val("rst_active", duty_active,    0);
    check_val("rst_seq",    seq_err,        0);

    // Free running, no duty: two wraps within 34 cycles, never high.
    n_hi = 0; n_wraps = 0;
    for (int i = 0; i < 34; i++) tick(1'b0, 5'd0);
    check_val("idle_hi",    n_hi,    0);
    check_val("idle_wraps", n_wraps, 2);

    // Duty 4 loaded at count 7.
    run_to(4'd7);
    tick(1'b1, 5'd4);
    check_val("d4_ready_lo", dif.duty_ready, 0);
    through_wrap();
    check_val("d4_active",   duty_active,    4);
    check_val("d4_ready_hi", dif.duty_ready, 1);
    n_hi = 0;
    for (int i = 0; i < 16; i++) tick(1'b0, 5'd0);
    check_val("d4_hi", n_hi, 4);

    // Full duty, then an over-range duty that must saturate.
    tick(1'b1, 5'd16);
    through_wrap();
    n_hi = 0;
    for (int i = 0; i < 16; i++) tick(1'b0, 5'd0);
    check_val("d16_hi",     n_hi,        16);
    check_val("d16_active", duty_active, 16);
    tick(1'b1, 5'd20);
    through_wrap();
    check_val("d20_active", duty_active, 16);

    // 6 accepted, 9 held until the slot frees after the wrap.
    tick(1'b1, 5'd6);
    begin
      int   waited;
      logic [3:0] at_cnt;
      waited = 0;
      at_cnt = 4'd0;
      last_xfer = 0;
      while (!last_xfer && waited < 40) begin
        at_cnt = cnt;
        tick(1'b1, 5'd9);
        waited++;
      end
      check_val("hold_xfer",     last_xfer,   1);
      check_val("hold_cnt",      at_cnt,      1);
      check_val("hold_active_6", duty_active, 6);
    end
    through_wrap();
    check_val("hold_active_9", duty_active, 9);

    // Sequence errors: skip 4,5,7; clear loses to a new skip; clear alone wins.
    run_to(4'd4);
    tick(1'b0, 5'd0);
    tick(1'b0, 5'd0);
    check_val("seq_clean", seq_err, 0);
    cnt = 4'd7;
    tick(1'b0, 5'd0);
    check_val("seq_set", seq_err, 1);
    tick(1'b0, 5'd0);
    tick(1'b0, 5'd0);
    cnt = 4'd12;
    step(1'b0, 1'b0, 5'd0, 1'b1);
    cnt = cnt + 4'd1;
    check_val("seq_clr_vs_err", seq_err, 1);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    cnt = cnt + 4'd1;
    check_val("seq_clr", seq_err, 0);

    // Reset with duty 8 pending: discarded, inverted output idles high.
    run_to(4'd3);
    tick(1'b1, 5'd8);
    check_val("pend8_ready", dif_i.duty_ready, 0);
    cnt = 4'd6;
    step(1'b1, 1'b0, 5'd0, 1'b0);
    check_val("rst2_active",  duty_active_i,    0);
    check_val("rst2_ready",   dif_i.duty_ready, 1);
    check_val("rst2_pwm_inv", pwm_out_i,        0);
    check_val("rst2_wrap",    wrap_pulse_i,     0);
    tick(1'b0, 5'd0);
    check_val("sync_pwm_inv", pwm_out_i, 1);
    check_val("sync_pwm",     pwm_out,   0);
    n_hi = 0;
    for (int i = 0; i < 36; i++) tick(1'b0, 5'd0);
    check_val("post_rst_hi",     n_hi,          0);
    check_val("post_rst_active", duty_active_i, 0);
    check_val("post_rst_pwm_inv", pwm_out_i,    1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
